// File: rtl/mem_arb_pkg.sv
// Shared types, constants and helpers for the round-robin memory port arbiter.
package mem_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_W       = $clog2(MAX_MASTERS);

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Rotate-priority distance of requester idx from the slot after last (0 = highest priority).
  function automatic int rr_dist(input int idx, input int last, input int n);
    return (idx - last - 1 + 2 * n) % n;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side native-protocol bundle of the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]    m_valid;
  logic [NUM_MASTERS*32-1:0] m_addr;
  logic [NUM_MASTERS*32-1:0] m_wdata;
  logic [NUM_MASTERS*4-1:0]  m_wstrb;
  logic [NUM_MASTERS-1:0]    m_ready;
  logic [NUM_MASTERS-1:0]    m_error;
  logic [31:0]               m_rdata;

  logic                      s_valid;
  logic [31:0]               s_addr;
  logic [31:0]               s_wdata;
  logic [3:0]                s_wstrb;
  logic                      s_ready;
  logic [31:0]               s_rdata;

  logic [NUM_MASTERS-1:0]    grant;
  logic                      timeout_err;

  // The arbiter itself.
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_error, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, timeout_err
  );

  // The surrounding system: requesters plus the memory.
  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_error, m_rdata, s_valid, s_addr, s_wdata, s_wstrb, grant, timeout_err
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational rotate-priority picker: the first set req bit after index last wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  int best;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    best = N;
    idx  = '0;
    gnt  = '0;
    for (int j = 0; j < N; j++) begin
      if (req[j] && (rr_dist(j, int'(last), N) < best)) begin
        best = rr_dist(j, int'(last), N);
        idx  = IDX_W'(j);
      end
    end
    // Distances are unique, so exactly one set request can match best.
    for (int j = 0; j < N; j++) begin
      gnt[j] = req[j] && (rr_dist(j, int'(last), N) == best);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one native memory port among NUM_MASTERS requesters,
// with a one-cycle release gap and a saturating stall timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   s_valid_q, s_valid_d;
  logic [31:0]            s_addr_q, s_addr_d;
  logic [31:0]            s_wdata_q, s_wdata_d;
  logic [3:0]             s_wstrb_q, s_wstrb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic [31:0]            win_addr, win_wdata;
  logic [3:0]             win_wstrb;
  logic                   busy, timeout_hit, done;

  mem_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req  (bus.m_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_wstrb = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (pick_idx == IDX_W'(j)) begin
        win_addr  = bus.m_addr[32*j +: 32];
        win_wdata = bus.m_wdata[32*j +: 32];
        win_wstrb = bus.m_wstrb[4*j +: 4];
      end
    end
  end

  // A real s_ready in the timeout cycle wins: it is a normal completion.
  assign busy        = (state_q == BUSY);
  assign timeout_hit = TIMEOUT_EN && busy && !bus.s_ready && (cnt_q == TIMEOUT_CNT);
  assign done        = busy && (bus.s_ready || timeout_hit);

  assign bus.m_ready     = done        ? grant_q : '0;
  assign bus.m_error     = timeout_hit ? grant_q : '0;
  assign bus.m_rdata     = (busy && bus.s_ready) ? bus.s_rdata : TIMEOUT_RDATA;
  assign bus.timeout_err = timeout_hit;
  assign bus.s_valid     = s_valid_q;
  assign bus.s_addr      = s_addr_q;
  assign bus.s_wdata     = s_wdata_q;
  assign bus.s_wstrb     = s_wstrb_q;
  assign bus.grant       = grant_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    s_valid_d = s_valid_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_valid) begin
          grant_d   = pick_gnt;
          idx_d     = pick_idx;
          s_addr_d  = win_addr;
          s_wdata_d = win_wdata;
          s_wstrb_d = win_wstrb;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          s_valid_d = 1'b0;
          grant_d   = '0;
          last_d    = idx_q;
          state_d   = RELEASE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_MASTERS - 1);
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      s_valid_q <= s_valid_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions plus
// hand-written contention, stray-ready and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  localparam int NM = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  mem_port_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    int          lat;        // BUSY cycle (0-based) in which memory answers; >40 means never
    logic [1:0]  exp_grant;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    int          exp_done;   // BUSY cycle (0-based) in which m_ready pulses
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: completes the current s_* request in this cycle.
  task automatic mem_respond();
    logic [31:0] w;
    bus.s_ready = 1'b1;
    if (bus.s_wstrb == 4'h0) begin
      bus.s_rdata = mem[bus.s_addr];
    end else begin
      w = mem[bus.s_addr];
      for (int b = 0; b < 4; b++)
        if (bus.s_wstrb[b]) w[8*b +: 8] = bus.s_wdata[8*b +: 8];
      mem[bus.s_addr] = w;
      bus.s_rdata = 32'h0;
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int   k;
    logic seen;
    @(negedge clk);
    bus.m_valid = v.req;
    bus.m_addr  = {v.a1, v.a0};
    bus.m_wdata = {v.d1, v.d0};
    bus.m_wstrb = {v.s1, v.s0};
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check($sformatf("v%0d s_valid latency", n), 32'(bus.s_valid), 32'd1);
    check($sformatf("v%0d grant", n), 32'(bus.grant), 32'(v.exp_grant));
    check($sformatf("v%0d s_addr", n), bus.s_addr, v.exp_addr);
    check($sformatf("v%0d s_wdata", n), bus.s_wdata, v.exp_wdata);
    check($sformatf("v%0d s_wstrb", n), 32'(bus.s_wstrb), 32'(v.exp_wstrb));
    seen = 1'b0;
    k = 0;
    while (!seen && k <= 40) begin
      if (k == v.lat) mem_respond();
      else begin
        bus.s_ready = 1'b0;
        bus.s_rdata = 32'hDEADBEEF;
      end
      #1;
      if (bus.m_ready != '0) begin
        seen = 1'b1;
        check($sformatf("v%0d done cycle", n), 32'(k), 32'(v.exp_done));
        check($sformatf("v%0d m_ready", n), 32'(bus.m_ready), 32'(v.exp_grant));
        check($sformatf("v%0d m_error", n), 32'(bus.m_error), v.exp_err ? 32'(v.exp_grant) : 32'd0);
        check($sformatf("v%0d m_rdata", n), bus.m_rdata, v.exp_rdata);
        check($sformatf("v%0d timeout_err", n), 32'(bus.timeout_err), 32'(v.exp_err));
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) check($sformatf("v%0d m_ready within bound", n), 32'd0, 32'd1);
    @(negedge clk);
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    #1;
    check($sformatf("v%0d release s_valid", n), 32'(bus.s_valid), 32'd0);
    check($sformatf("v%0d release grant", n), 32'(bus.grant), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int txn, low_run, busy_cyc;
    logic [1:0] exp_g;

    mem[32'h100] = 32'hCAFEBABE;
    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h0BADF00D;

    //           req    a0        a1        d0            d1            s0    s1     lat gnt    addr      wdata         wstrb    rdata         done err
    vecs[0] = '{2'b01, 32'h100,  32'h300,  32'h0,        32'h0,        4'h0, 4'h0,   0, 2'b01, 32'h100, 32'h0,        4'h0,    32'hCAFEBABE, 0,  1'b0};
    vecs[1] = '{2'b10, 32'h100,  32'h200,  32'h12345678, 32'hA5A5A5A5, 4'hF, 4'h5,   0, 2'b10, 32'h200, 32'hA5A5A5A5, 4'b0101, 32'h0,        0,  1'b0};
    vecs[2] = '{2'b01, 32'h200,  32'h100,  32'h0,        32'hFFFFFFFF, 4'h0, 4'hF,   2, 2'b01, 32'h200, 32'h0,        4'h0,    32'h11A533A5, 2,  1'b0};
    vecs[3] = '{2'b11, 32'h300,  32'h100,  32'h0,        32'h0,        4'h0, 4'h0,   1, 2'b10, 32'h100, 32'h0,        4'h0,    32'hCAFEBABE, 1,  1'b0};
    vecs[4] = '{2'b11, 32'h300,  32'h200,  32'h0,        32'h0,        4'h0, 4'h0,   0, 2'b01, 32'h300, 32'h0,        4'h0,    32'h0BADF00D, 0,  1'b0};
    vecs[5] = '{2'b10, 32'h100,  32'h100,  32'h0,        32'h0,        4'h0, 4'h0,  99, 2'b10, 32'h100, 32'h0,        4'h0,    32'h0,        16, 1'b1};
    vecs[6] = '{2'b01, 32'h100,  32'h200,  32'h0,        32'h0,        4'h0, 4'h0,  16, 2'b01, 32'h100, 32'h0,        4'h0,    32'hCAFEBABE, 16, 1'b0};
    vecs[7] = '{2'b10, 32'h100,  32'h300,  32'h0,        32'h0,        4'h0, 4'h0,   1, 2'b10, 32'h300, 32'h0,        4'h0,    32'h0BADF00D, 1,  1'b0};

    reset       = 1'b1;
    bus.m_valid = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = 32'h0;
    #1;
    check("reset s_valid", 32'(bus.s_valid), 32'd0);
    check("reset grant", 32'(bus.grant), 32'd0);
    check("reset m_ready", 32'(bus.m_ready), 32'd0);
    check("reset m_error", 32'(bus.m_error), 32'd0);
    check("reset m_rdata", bus.m_rdata, 32'd0);
    check("reset timeout_err", 32'(bus.timeout_err), 32'd0);
    check("reset s_addr", bus.s_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Contention: both masters request continuously; last is 1, so master 0 leads.
    // Each transaction leaves s_valid low for the RELEASE cycle plus the arbitration cycle.
    @(negedge clk);
    bus.m_valid = 2'b11;
    bus.m_addr  = {32'h300, 32'h100};
    bus.m_wstrb = '0;
    txn = 0;
    low_run = 0;
    busy_cyc = 0;
    for (int c = 0; c < 60 && txn < 6; c++) begin
      @(negedge clk);
      bus.s_ready = 1'b0;
      exp_g = (txn % 2 == 0) ? 2'b01 : 2'b10;
      if (bus.s_valid) begin
        if (busy_cyc == 0) begin
          check($sformatf("rr txn%0d grant", txn), 32'(bus.grant), 32'(exp_g));
          if (txn > 0) check($sformatf("rr txn%0d s_valid gap", txn), 32'(low_run), 32'd2);
        end
        low_run = 0;
        if (busy_cyc == 1) begin
          mem_respond();
          #1;
          check($sformatf("rr txn%0d m_ready", txn), 32'(bus.m_ready), 32'(exp_g));
          txn++;
        end
        busy_cyc++;
      end else begin
        busy_cyc = 0;
        low_run++;
      end
    end
    check("rr six transactions done", 32'(txn), 32'd6);
    @(negedge clk);
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    repeat (2) @(negedge clk);

    // Stray s_ready while idle must not complete anything.
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h12345678;
    #1;
    check("stray m_ready", 32'(bus.m_ready), 32'd0);
    check("stray m_error", 32'(bus.m_error), 32'd0);
    @(negedge clk);
    bus.s_ready = 1'b0;
    check("stray s_valid", 32'(bus.s_valid), 32'd0);
    check("stray grant", 32'(bus.grant), 32'd0);

    // Asynchronous reset in the middle of a BUSY transaction.
    bus.m_valid = 2'b10;
    bus.m_addr  = {32'h200, 32'h100};
    @(negedge clk);
    check("pre-reset s_valid", 32'(bus.s_valid), 32'd1);
    check("pre-reset grant", 32'(bus.grant), 32'b10);
    #2;
    reset = 1'b1;
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h55AA55AA;
    #1;
    check("async reset s_valid", 32'(bus.s_valid), 32'd0);
    check("async reset grant", 32'(bus.grant), 32'd0);
    check("async reset m_ready", 32'(bus.m_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b11;
    @(negedge clk);
    check("post-reset s_valid", 32'(bus.s_valid), 32'd1);
    check("post-reset grant", 32'(bus.grant), 32'b01);
    mem_respond();
    #1;
    check("post-reset m_ready", 32'(bus.m_ready), 32'b01);
    check("post-reset m_rdata", bus.m_rdata, 32'hCAFEBABE);
    @(negedge clk);
    bus.s_ready = 1'b0;
    bus.m_valid = '0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
